// File: rtl/vram_arb_pkg.sv
// Shared types for the frame-buffer arbiter: FSM state and per-cycle grant encoding.
package vram_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_VID,
      S_HOST_RD,
      S_HOST_WR
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_VID,
      GNT_HOST
   } grant_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the scan-out, host and RAM-side signals of the frame-buffer arbiter.
interface vram_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);

   logic                  i_vid_valid;
   logic [ADDR_WIDTH-1:0] i_vid_addr;
   logic                  o_vid_ready;
   logic                  o_vid_rvalid;
   logic [DATA_WIDTH-1:0] o_vid_rdata;

   logic                  i_host_valid;
   logic                  i_host_write;
   logic [ADDR_WIDTH-1:0] i_host_addr;
   logic [DATA_WIDTH-1:0] i_host_wdata;
   logic                  o_host_ready;
   logic                  o_host_rvalid;
   logic [DATA_WIDTH-1:0] o_host_rdata;

   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic                  o_mem_write;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic [DATA_WIDTH-1:0] i_mem_rdata;

   // Arbiter side
   modport slave (
      input  i_vid_valid, i_vid_addr,
      output o_vid_ready, o_vid_rvalid, o_vid_rdata,
      input  i_host_valid, i_host_write, i_host_addr, i_host_wdata,
      output o_host_ready, o_host_rvalid, o_host_rdata,
      output o_mem_addr, o_mem_write, o_mem_wdata,
      input  i_mem_rdata
   );

   // Requester / RAM side
   modport master (
      output i_vid_valid, i_vid_addr,
      input  o_vid_ready, o_vid_rvalid, o_vid_rdata,
      output i_host_valid, i_host_write, i_host_addr, i_host_wdata,
      input  o_host_ready, o_host_rvalid, o_host_rdata,
      input  o_mem_addr, o_mem_write, o_mem_wdata,
      output i_mem_rdata
   );

endinterface

// File: rtl/vram_arb_grant.sv
// Per-cycle grant decision: scan-out first unless the host is being forced through.
module vram_arb_grant
   import vram_arb_pkg::*;
(
   input  logic   vid_valid,
   input  logic   host_valid,
   input  logic   force_host,
   output grant_t grant
);

   always_comb begin
      grant = GNT_NONE;
      if (vid_valid && !force_host) begin
         grant = GNT_VID;
      end else if (host_valid) begin
         grant = GNT_HOST;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: scan-out priority, host in idle cycles.
// Optional starvation guard enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int STARVE_LIMIT = 4
) (
   input logic           i_clk,
   input logic           i_rst_n,
   vram_arbiter_if.slave bus
);

   grant_t                grant;
   logic                  force_host;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_write_q, mem_write_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  vid_rvalid_q, host_rvalid_q;

   vram_arb_grant u_grant (
      .vid_valid  (bus.i_vid_valid),
      .host_valid (bus.i_host_valid),
      .force_host (force_host),
      .grant      (grant)
   );

`ifdef VRAM_ARB_STARVE_GUARD_EN
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
   logic [7:0] starve_cnt;

   assign force_host = bus.i_host_valid && (starve_cnt == LIMIT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_cnt <= '0;
      end else if (!bus.i_host_valid || grant == GNT_HOST) begin
         starve_cnt <= '0;
      end else if (grant == GNT_VID && starve_cnt != 8'hFF) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end
`else
   // Strict priority: the limit has no effect in this build
   assign force_host = (STARVE_LIMIT < 0);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = S_IDLE;
      case (grant)
         GNT_VID:  state_d = S_VID;
         GNT_HOST: state_d = bus.i_host_write ? S_HOST_WR : S_HOST_RD;
         default:  state_d = S_IDLE;
      endcase
   end

   // Command stage: idle cycles hold address/data and drop the write enable
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_write_d = 1'b0;
      case (grant)
         GNT_VID: mem_addr_d = bus.i_vid_addr;
         GNT_HOST: begin
            mem_addr_d  = bus.i_host_addr;
            mem_write_d = bus.i_host_write;
            if (bus.i_host_write) mem_wdata_d = bus.i_host_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mem_addr_q    <= '0;
         mem_write_q   <= 1'b0;
         mem_wdata_q   <= '0;
         vid_rvalid_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
      end else begin
         mem_addr_q    <= mem_addr_d;
         mem_write_q   <= mem_write_d;
         mem_wdata_q   <= mem_wdata_d;
         // Return stage: RAM data lands one edge after the command edge
         vid_rvalid_q  <= (state_q == S_VID);
         host_rvalid_q <= (state_q == S_HOST_RD);
      end
   end

   // Ready is masked during reset so nothing is accepted while held
   assign bus.o_vid_ready   = i_rst_n && (grant == GNT_VID);
   assign bus.o_host_ready  = i_rst_n && (grant == GNT_HOST);
   assign bus.o_mem_addr    = mem_addr_q;
   assign bus.o_mem_write   = mem_write_q;
   assign bus.o_mem_wdata   = mem_wdata_q;
   assign bus.o_vid_rvalid  = vid_rvalid_q;
   assign bus.o_host_rvalid = host_rvalid_q;
   assign bus.o_vid_rdata   = vid_rvalid_q  ? bus.i_mem_rdata : '0;
   assign bus.o_host_rdata  = host_rvalid_q ? bus.i_mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural registered-read single-port RAM.
module tb_vram_arbiter;
   import vram_arb_pkg::*;

`ifdef VRAM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   vram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

   vram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STARVE_LIMIT(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic       load_en;
   logic [7:0] load_addr;
   logic [7:0] load_data;
   logic [7:0] ram [256];

   // Writes do not update the read register
   always @(posedge clk) begin
      if (load_en) ram[load_addr] <= load_data;
      else if (bus.o_mem_write) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
      else bus.i_mem_rdata <= ram[bus.o_mem_addr];
   end

   typedef struct {
      logic       vv;
      logic [7:0] va;
      logic       hv;
      logic       hw;
      logic [7:0] ha;
      logic [7:0] hd;
      logic       vr;
      logic       vrv;
      logic [7:0] vrd;
      logic       hr;
      logic       hrv;
      logic [7:0] hrd;
      logic       mw;
      logic [7:0] ma;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(logic vv, logic [7:0] va, logic hv, logic hw, logic [7:0] ha,
                               logic [7:0] hd, logic vr, logic vrv, logic [7:0] vrd, logic hr,
                               logic hrv, logic [7:0] hrd, logic mw, logic [7:0] ma);
      vec_t v;
      v.vv = vv; v.va = va; v.hv = hv; v.hw = hw; v.ha = ha; v.hd = hd;
      v.vr = vr; v.vrv = vrv; v.vrd = vrd; v.hr = hr; v.hrv = hrv; v.hrd = hrd;
      v.mw = mw; v.ma = ma;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic vv, input logic [7:0] va, input logic hv, input logic hw,
                        input logic [7:0] ha, input logic [7:0] hd);
      bus.i_vid_valid  = vv;
      bus.i_vid_addr   = va;
      bus.i_host_valid = hv;
      bus.i_host_write = hw;
      bus.i_host_addr  = ha;
      bus.i_host_wdata = hd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      load_en = 1'b0;
      load_addr = '0;
      load_data = '0;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

      // Preload the RAM while the arbiter is held in reset
      for (int i = 0; i < 4; i++) begin
         load_en = 1'b1; load_addr = 8'h10 + 8'(i); load_data = 8'hA0 + 8'(i);
         next_cycle();
      end
      load_addr = 8'h20; load_data = 8'h11;
      next_cycle();
      load_en = 1'b0;

      @(negedge clk);
      check("rst_vid_rvalid", 32'(bus.o_vid_rvalid), 0);
      check("rst_host_rvalid", 32'(bus.o_host_rvalid), 0);
      check("rst_mem_write", 32'(bus.o_mem_write), 0);
      check("rst_mem_addr", 32'(bus.o_mem_addr), 0);
      check("rst_mem_wdata", 32'(bus.o_mem_wdata), 0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      vecs[0]  = mk(1, 8'h10, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
      vecs[1]  = mk(1, 8'h11, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h10);
      vecs[2]  = mk(1, 8'h12, 0, 0, 8'h00, 8'h00, 1, 1, 8'hA0, 0, 0, 8'h00, 0, 8'h11);
      vecs[3]  = mk(1, 8'h13, 0, 0, 8'h00, 8'h00, 1, 1, 8'hA1, 0, 0, 8'h00, 0, 8'h12);
      vecs[4]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'hA2, 0, 0, 8'h00, 0, 8'h13);
      vecs[5]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'hA3, 0, 0, 8'h00, 0, 8'h13);
      vecs[6]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h13);
      vecs[7]  = mk(0, 8'h00, 1, 1, 8'h20, 8'h55, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h13);
      vecs[8]  = mk(0, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h20);
      vecs[9]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h20);
      vecs[10] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 8'h55, 0, 8'h20);
      vecs[11] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h20);
      vecs[12] = mk(1, 8'h13, 1, 1, 8'h13, 8'h77, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h20);
      vecs[13] = mk(0, 8'h00, 1, 1, 8'h13, 8'h77, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h13);
      vecs[14] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'hA3, 0, 0, 8'h00, 1, 8'h13);
      vecs[15] = mk(1, 8'h13, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h13);
      vecs[16] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h13);
      vecs[17] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'h77, 0, 0, 8'h00, 0, 8'h13);

      for (int r = 0; r < 18; r++) begin
         drive(vecs[r].vv, vecs[r].va, vecs[r].hv, vecs[r].hw, vecs[r].ha, vecs[r].hd);
         @(negedge clk);
         check($sformatf("v%0d_vid_ready", r), 32'(bus.o_vid_ready), 32'(vecs[r].vr));
         check($sformatf("v%0d_vid_rvalid", r), 32'(bus.o_vid_rvalid), 32'(vecs[r].vrv));
         if (vecs[r].vrv)
            check($sformatf("v%0d_vid_rdata", r), 32'(bus.o_vid_rdata), 32'(vecs[r].vrd));
         check($sformatf("v%0d_host_ready", r), 32'(bus.o_host_ready), 32'(vecs[r].hr));
         check($sformatf("v%0d_host_rvalid", r), 32'(bus.o_host_rvalid), 32'(vecs[r].hrv));
         if (vecs[r].hrv)
            check($sformatf("v%0d_host_rdata", r), 32'(bus.o_host_rdata), 32'(vecs[r].hrd));
         check($sformatf("v%0d_mem_write", r), 32'(bus.o_mem_write), 32'(vecs[r].mw));
         check($sformatf("v%0d_mem_addr", r), 32'(bus.o_mem_addr), 32'(vecs[r].ma));
         next_cycle();
      end

      // Continuous contention: strict priority, or a forced host slot every fifth cycle
      for (int c = 0; c < 10; c++) begin
         logic exp_host;
         logic exp_mw;
         exp_host = GUARD && (c % 5 == 4);
         exp_mw   = GUARD && (c > 0) && ((c - 1) % 5 == 4);
         drive(1'b1, 8'h30, 1'b1, 1'b1, 8'h31, 8'h99);
         @(negedge clk);
         check($sformatf("c%0d_host_ready", c), 32'(bus.o_host_ready), 32'(exp_host));
         check($sformatf("c%0d_vid_ready", c), 32'(bus.o_vid_ready), 32'(!exp_host));
         check($sformatf("c%0d_mem_write", c), 32'(bus.o_mem_write), 32'(exp_mw));
         next_cycle();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) next_cycle();

      // Reset one cycle after a video accept: outputs clear at once, no late return
      drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
      next_cycle();
      rst_n = 1'b0;
      #1;
      check("ar_vid_ready", 32'(bus.o_vid_ready), 0);
      check("ar_host_ready", 32'(bus.o_host_ready), 0);
      check("ar_vid_rvalid", 32'(bus.o_vid_rvalid), 0);
      check("ar_host_rvalid", 32'(bus.o_host_rvalid), 0);
      check("ar_vid_rdata", 32'(bus.o_vid_rdata), 0);
      check("ar_mem_addr", 32'(bus.o_mem_addr), 0);
      check("ar_mem_write", 32'(bus.o_mem_write), 0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("post_rst%0d_vid_rvalid", i), 32'(bus.o_vid_rvalid), 0);
         check($sformatf("post_rst%0d_host_rvalid", i), 32'(bus.o_host_rvalid), 0);
         check($sformatf("post_rst%0d_mem_addr", i), 32'(bus.o_mem_addr), 0);
         next_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
